latch_output_monitor: RTL and testbench
=======================================

LATCH_OUTPUT_MONITOR -- requirements
Module: latch_output_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each edge counter.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (minimum 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port q_in  input  1  latch output q, asynchronous to clk.
REQ-006 SHALL have port clear  input  1  synchronous clear of both counters.
REQ-007 SHALL have port snap  input  1  request a counter snapshot.
REQ-008 SHALL have port rpt_ready  input  1  downstream accepts snapshot.
REQ-009 SHALL have port level  output  1  synchronized q_in.
REQ-010 SHALL have port rise_pulse  output  1  one-cycle pulse per rising edge of level.
REQ-011 SHALL have port fall_pulse  output  1  one-cycle pulse per falling edge of level.
REQ-012 SHALL have port rise_cnt  output  CNT_W  rising-edge count.
REQ-013 SHALL have port fall_cnt  output  CNT_W  falling-edge count.
REQ-014 SHALL have port rpt_valid  output  1  snapshot available.
REQ-015 SHALL have port rpt_data  output  2*CNT_W  snapshot, {rise_cnt, fall_cnt}.

Function
REQ-016 SHALL pass q_in through a SYNC_STAGES-deep flop chain; level is the last stage.
REQ-017 SHALL hold prev, level delayed one cycle; edge rise = level & ~prev, fall = ~level & prev.
REQ-018 SHALL register rise_pulse/fall_pulse, so a q_in transition stable before edge N shows as a pulse in the cycle after edge N+SYNC_STAGES (3 edges with default).
REQ-019 SHALL increment rise_cnt/fall_cnt on the same edge that sets the matching pulse.
REQ-020 SHALL saturate counters at 2^CNT_W-1; no wrap-around.
REQ-021 SHALL zero both counters on an edge with clear=1; clear wins over a simultaneous increment.
REQ-022 SHALL ignore q_in pulses shorter than one clk period only as far as the synchronizer drops them; no debounce is required.
REQ-023 SHALL implement report FSM with states IDLE and VALID; rpt_valid=1 exactly in VALID.
REQ-024 IDLE: on snap=1, SHALL load rpt_data with current (pre-increment, pre-clear) counter values and go to VALID.
REQ-025 VALID: SHALL hold rpt_data stable; on rpt_ready=1 go to IDLE; snap in VALID is ignored.
REQ-026 SHALL not take a new snapshot in the handshake cycle itself; earliest next snapshot is the following cycle.

Reset
REQ-027 SHALL on rst_n=0, asynchronously clear synchronizer, prev, level, pulses, counters, rpt_data to 0 and FSM to IDLE.
REQ-028 SHALL abandon an outstanding report when reset asserts mid-handshake; rpt_valid drops immediately.
REQ-029 SHALL not generate a rise_pulse after reset release while q_in is already high until level reaches 1 through the synchronizer (one rise then counted).

Structure
REQ-030 SHALL place FSM state encoding (IDLE, VALID) and default CNT_W in a shared package, latch_mon_pkg.
REQ-031 SHALL use one sub-module, sync_2ff, parameterized by stage count, for the synchronizer.

Verification
REQ-032 Reset, q_in=0, 3 clocks; drive q_in=1 -> rise_pulse=1 for one cycle 3 edges later, rise_cnt=1, fall_cnt=0.
REQ-033 Toggle q_in 300 times (150 rises), CNT_W=8 -> rise_cnt=150, fall_cnt=150; then 200 more rises -> rise_cnt=255 saturated.
REQ-034 clear=1 on the same edge as a rise -> rise_cnt=0 next cycle, rise_pulse still 1.
REQ-035 rise_cnt=5, fall_cnt=4, snap=1, rpt_ready=0 for 4 cycles -> rpt_valid=1, rpt_data=16'h0504 stable, extra snaps ignored; rpt_ready=1 -> rpt_valid=0 next cycle.
REQ-036 snap=1 and clear=1 same edge with counts 7/7 -> rpt_data=16'h0707, counters 0.
REQ-037 rst_n=0 asynchronously while rpt_valid=1 -> rpt_valid, counters, level all 0 before next clk edge.

Source files
------------

// File: rtl/latch_mon_pkg.sv
// Shared definitions for the latch output monitor: report FSM encoding and
// the default counter width.
package latch_mon_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } rpt_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flop synchronizer for a single asynchronous bit; the output is
// the last stage of the chain.
module sync_2ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/latch_output_monitor.sv
// Watches an asynchronous latch output: synchronizes it, flags and counts its
// edges with saturating counters, and offers counter snapshots over a valid/ready report.
module latch_output_monitor
  import latch_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               q_in,
  input  logic               clear,
  input  logic               snap,
  input  logic               rpt_ready,
  output logic               level,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic [CNT_W-1:0]   rise_cnt,
  output logic [CNT_W-1:0]   fall_cnt,
  output logic               rpt_valid,
  output logic [2*CNT_W-1:0] rpt_data
);

  logic               w_level;
  logic               r_prev;
  logic               w_rise;
  logic               w_fall;
  logic               r_rise_pulse;
  logic               r_fall_pulse;
  logic [CNT_W-1:0]   r_rise_cnt;
  logic [CNT_W-1:0]   r_fall_cnt;
  logic [2*CNT_W-1:0] r_rpt_data;
  rpt_state_t         r_state;
  rpt_state_t         w_state_nxt;
  logic               w_load;

  sync_2ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (q_in),
    .o_q  (w_level)
  );

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= 1'b0;
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
    end else begin
      r_prev       <= w_level;
      r_rise_pulse <= w_rise;
      r_fall_pulse <= w_fall;
    end
  end

  // Counters stop at all-ones; clear overrides any increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
    end else if (clear) begin
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
    end else begin
      if (w_rise && (r_rise_cnt != '1)) r_rise_cnt <= r_rise_cnt + 1'b1;
      if (w_fall && (r_fall_cnt != '1)) r_fall_cnt <= r_fall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The handshake edge only returns to IDLE, so a snap held through it is
  // taken on the following edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (snap) begin
          w_load      = 1'b1;
          w_state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (rpt_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_data <= '0;
    end else if (w_load) begin
      r_rpt_data <= {r_rise_cnt, r_fall_cnt};
    end
  end

  assign level      = w_level;
  assign rise_pulse = r_rise_pulse;
  assign fall_pulse = r_fall_pulse;
  assign rise_cnt   = r_rise_cnt;
  assign fall_cnt   = r_fall_cnt;
  assign rpt_valid  = (r_state == ST_VALID);
  assign rpt_data   = r_rpt_data;

endmodule

// File: tb/tb_latch_output_monitor.sv
// Scoreboard bench for latch_output_monitor: expected counts and snapshots are
// queued at stimulus time and compared when pulses / rpt_valid appear.
module tb_latch_output_monitor;

  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              q_in = 1'b0;
  logic              clear = 1'b0;
  logic              snap = 1'b0;
  logic              rpt_ready = 1'b0;
  logic              level;
  logic              rise_pulse;
  logic              fall_pulse;
  logic [CNT_W-1:0]  rise_cnt;
  logic [CNT_W-1:0]  fall_cnt;
  logic              rpt_valid;
  logic [2*CNT_W-1:0] rpt_data;

  typedef struct {
    int rise;
    int fall;
  } cnt_exp_t;

  cnt_exp_t     edge_q[$];
  logic [15:0]  rpt_q[$];
  int checks = 0;
  int errors = 0;
  int m_rise = 0;
  int m_fall = 0;

  latch_output_monitor #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q_in      (q_in),
    .clear     (clear),
    .snap      (snap),
    .rpt_ready (rpt_ready),
    .level     (level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .rise_cnt  (rise_cnt),
    .fall_cnt  (fall_cnt),
    .rpt_valid (rpt_valid),
    .rpt_data  (rpt_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset(input logic qv);
    rst_n = 1'b0;
    q_in = qv;
    clear = 1'b0;
    snap = 1'b0;
    rpt_ready = 1'b0;
    m_rise = 0;
    m_fall = 0;
    edge_q.delete();
    rpt_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one q_in transition at a negedge, waits (bounded) for its pulse and
  // checks the counters against the queued expectation.
  task automatic drive_edge(input logic v);
    cnt_exp_t e;
    bit seen;
    q_in = v;
    if (v) m_rise = (m_rise < CMAX) ? m_rise + 1 : CMAX;
    else   m_fall = (m_fall < CMAX) ? m_fall + 1 : CMAX;
    edge_q.push_back('{rise: m_rise, fall: m_fall});
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (v ? rise_pulse : fall_pulse) begin
        seen = 1;
        break;
      end
    end
    e = edge_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL edge_timeout: no %s pulse within 8 cycles (got 0, want 1)", v ? "rise" : "fall");
    end else if (rise_cnt !== CNT_W'(e.rise) || fall_cnt !== CNT_W'(e.fall)) begin
      errors++;
      $display("FAIL edge_counts: got rise=%0d fall=%0d, want rise=%0d fall=%0d",
               rise_cnt, fall_cnt, e.rise, e.fall);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if ({level, rise_pulse, fall_pulse, rise_cnt, fall_cnt, rpt_valid, rpt_data} !== '0) begin
      errors++;
      $display("FAIL reset_state: got lvl=%b rp=%b fp=%b rc=%0d fc=%0d v=%b d=%h, want all 0",
               level, rise_pulse, fall_pulse, rise_cnt, fall_cnt, rpt_valid, rpt_data);
    end
  endtask

  task automatic test_first_rise();
    cnt_exp_t e;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    q_in = 1'b1;
    m_rise = 1;
    edge_q.push_back('{rise: 1, fall: 0});
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (rise_pulse !== (i == 3)) begin
        errors++;
        $display("FAIL first_rise_pulse: cycle %0d got %b, want %b", i, rise_pulse, (i == 3));
      end
      if (i == 3) begin
        e = edge_q.pop_front();
        checks++;
        if (rise_cnt !== CNT_W'(e.rise) || fall_cnt !== CNT_W'(e.fall)) begin
          errors++;
          $display("FAIL first_rise_cnt: got %0d/%0d, want %0d/%0d", rise_cnt, fall_cnt, e.rise, e.fall);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    repeat (150) begin
      drive_edge(1'b1);
      drive_edge(1'b0);
    end
    checks++;
    if (rise_cnt !== 8'd150 || fall_cnt !== 8'd150) begin
      errors++;
      $display("FAIL toggle_150: got %0d/%0d, want 150/150", rise_cnt, fall_cnt);
    end
    repeat (200) begin
      drive_edge(1'b1);
      drive_edge(1'b0);
    end
    checks++;
    if (rise_cnt !== 8'd255 || fall_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturate: got %0d/%0d, want 255/255", rise_cnt, fall_cnt);
    end
  endtask

  task automatic test_clear_on_rise();
    do_reset(1'b0);
    drive_edge(1'b1);
    drive_edge(1'b0);
    q_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_rise = 0;
    m_fall = 0;
    checks++;
    if (rise_pulse !== 1'b1 || rise_cnt !== 8'd0 || fall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clear_vs_rise: got pulse=%b rc=%0d fc=%0d, want pulse=1 rc=0 fc=0",
               rise_pulse, rise_cnt, fall_cnt);
    end
    @(negedge clk);
    checks++;
    if (rise_pulse !== 1'b0 || rise_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clear_after: got pulse=%b rc=%0d, want 0/0", rise_pulse, rise_cnt);
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] exp;
    do_reset(1'b0);
    repeat (4) begin
      drive_edge(1'b1);
      drive_edge(1'b0);
    end
    drive_edge(1'b1);
    snap = 1'b1;
    rpt_q.push_back({8'(m_rise), 8'(m_fall)});
    q_in = 1'b0;
    m_fall = m_fall + 1;
    exp = 16'hxxxx;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) exp = rpt_q.pop_front();
      checks++;
      if (rpt_valid !== 1'b1 || rpt_data !== exp || exp !== 16'h0504) begin
        errors++;
        $display("FAIL snap_hold: cycle %0d got v=%b d=%h, want v=1 d=0504", i, rpt_valid, rpt_data);
      end
    end
    checks++;
    if (fall_cnt !== 8'd5) begin
      errors++;
      $display("FAIL snap_live_cnt: got fall=%0d, want 5", fall_cnt);
    end
    rpt_ready = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0;
    rpt_q.push_back({8'(m_rise), 8'(m_fall)});
    checks++;
    if (rpt_valid !== 1'b0) begin
      errors++;
      $display("FAIL snap_handshake: got v=%b, want 0", rpt_valid);
    end
    @(negedge clk);
    snap = 1'b0;
    exp = rpt_q.pop_front();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_data !== exp) begin
      errors++;
      $display("FAIL snap_next: got v=%b d=%h, want v=1 d=%h", rpt_valid, rpt_data, exp);
    end
    rpt_ready = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0;
  endtask

  task automatic test_snap_clear();
    logic [15:0] exp;
    do_reset(1'b0);
    repeat (7) begin
      drive_edge(1'b1);
      drive_edge(1'b0);
    end
    snap = 1'b1;
    clear = 1'b1;
    rpt_q.push_back({8'(m_rise), 8'(m_fall)});
    @(negedge clk);
    snap = 1'b0;
    clear = 1'b0;
    m_rise = 0;
    m_fall = 0;
    exp = rpt_q.pop_front();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_data !== exp || exp !== 16'h0707 || rise_cnt !== 8'd0 || fall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL snap_clear: got v=%b d=%h rc=%0d fc=%0d, want v=1 d=0707 rc=0 fc=0",
               rpt_valid, rpt_data, rise_cnt, fall_cnt);
    end
    rpt_ready = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0;
  endtask

  task automatic test_reset_midhandshake();
    logic [15:0] exp;
    do_reset(1'b0);
    drive_edge(1'b1);
    snap = 1'b1;
    rpt_q.push_back({8'(m_rise), 8'(m_fall)});
    @(negedge clk);
    snap = 1'b0;
    exp = rpt_q.pop_front();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_data !== exp) begin
      errors++;
      $display("FAIL pre_reset_valid: got v=%b d=%h, want v=1 d=%h", rpt_valid, rpt_data, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rpt_valid !== 1'b0 || rise_cnt !== 8'd0 || fall_cnt !== 8'd0 || level !== 1'b0 || rpt_data !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got v=%b rc=%0d fc=%0d lvl=%b d=%h, want all 0",
               rpt_valid, rise_cnt, fall_cnt, level, rpt_data);
    end
    m_rise = 0;
    m_fall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (rise_pulse !== (i == 3) || level !== (i >= 2)) begin
        errors++;
        $display("FAIL release_high: cycle %0d got pulse=%b lvl=%b, want pulse=%b lvl=%b",
                 i, rise_pulse, level, (i == 3), (i >= 2));
      end
    end
    checks++;
    if (rise_cnt !== 8'd1 || fall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL release_cnt: got %0d/%0d, want 1/0", rise_cnt, fall_cnt);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_first_rise();
    test_saturation();
    test_clear_on_rise();
    test_snapshot();
    test_snap_clear();
    test_reset_midhandshake();
    checks++;
    if (edge_q.size() != 0 || rpt_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, want 0/0", edge_q.size(), rpt_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
